// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
// Provides the bus word width and word type.
package mem_responder_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: word storage, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module mem_array #(
  parameter int ADDR_BITS = 8,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

  // No reset: contents survive reset_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: four-phase memory slave with fixed response latency.
// Ports: clk, reset_n, readM/writeM/address in, data inout,
// inputReady (read data valid), ackOutput (write done).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [2:0]           state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_q;
  word_t                data_q;
  word_t                rdata;
  logic                 mem_we;
  logic                 unused_hi;

  // High address bits alias away.
  assign unused_hi = ^address[WORD_SIZE-1:ADDR_BITS];

  // Write lands on the same edge that enters WR_RESP.
  assign mem_we = (state == WR_WAIT) && writeM && (cnt == 4'd0);

  mem_array #(
    .ADDR_BITS(ADDR_BITS),
    .WORD_SIZE(WORD_SIZE)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_q),
    .wdata(data_q),
    .raddr(addr_q),
    .rdata(rdata)
  );

  assign data = (state == RD_RESP) ? rdata : 'z;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      inputReady <= 1'b0;
      ackOutput  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (writeM) begin
            addr_q <= address[ADDR_BITS-1:0];
            data_q <= data;
            cnt    <= CNT_LOAD;
            state  <= WR_WAIT;
          end else if (readM) begin
            addr_q <= address[ADDR_BITS-1:0];
            cnt    <= CNT_LOAD;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!readM) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state      <= RD_RESP;
            inputReady <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_WAIT: begin
          if (!writeM) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state     <= WR_RESP;
            ackOutput <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_RESP: begin
          if (!readM) begin
            state      <= IDLE;
            inputReady <= 1'b0;
          end
        end
        WR_RESP: begin
          if (!writeM) begin
            state     <= IDLE;
            ackOutput <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          inputReady <= 1'b0;
          ackOutput  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at LATENCY 2, 1 and 15.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_mem_responder;

  localparam logic [15:0] PARK = 16'hA5A5;

  typedef struct {
    int          d;
    bit          wr;
    logic [15:0] data;
    int          sample;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_a   [3];
  logic        wr_a   [3];
  logic [15:0] addr_a [3];
  logic        drv_a  [3];
  logic [15:0] dout_a [3];
  logic [15:0] bus_mon[3];
  logic        ir_a   [3];
  logic        ack_a  [3];
  logic        ir_p   [3];
  logic        ack_p  [3];
  logic [15:0] hold_v [3];

  int          cyc = 0;
  int          ntests = 0;
  int          nfail = 0;
  exp_t        exp_q[$];
  logic [15:0] model [3][256];
  logic [15:0] known [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    wire [15:0] bus;
    assign bus = drv_a[g] ? dout_a[g] : 'z;
    assign bus_mon[g] = bus;
    mem_responder #(.LATENCY(L), .ADDR_BITS(8)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .readM     (rd_a[g]),
      .writeM    (wr_a[g]),
      .address   (addr_a[g]),
      .data      (bus),
      .inputReady(ir_a[g]),
      .ackOutput (ack_a[g])
    );
  end

  task automatic pop_check(int g, bit kind, logic [15:0] v);
    exp_t e;
    ntests++;
    if (exp_q.size() == 0) begin
      nfail++;
      $display("FAIL unexpected_resp dut%0d kind=%0d got=%h", g, kind, v);
    end else begin
      e = exp_q.pop_front();
      if (e.d != g || e.wr != kind ||
          cyc != e.sample + lat_of(g) ||
          (!kind && v !== e.data)) begin
        nfail++;
        $display("FAIL resp dut%0d: got kind=%0d data=%h edges=%0d, need dut%0d kind=%0d data=%h edges=%0d",
                 g, kind, v, cyc - e.sample, e.d, e.wr, e.data, lat_of(g));
      end
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ir_a[g] && ack_a[g]) begin
        ntests++;
        nfail++;
        $display("FAIL both_high dut%0d got ir=1 ack=1, need not both", g);
      end
      if (ir_a[g] && !ir_p[g]) begin
        pop_check(g, 1'b0, bus_mon[g]);
        hold_v[g] <= bus_mon[g];
      end else if (ir_a[g]) begin
        ntests++;
        if (bus_mon[g] !== hold_v[g]) begin
          nfail++;
          $display("FAIL hold dut%0d got=%h need=%h", g, bus_mon[g], hold_v[g]);
        end
      end
      if (ack_a[g] && !ack_p[g]) pop_check(g, 1'b1, 16'h0);
      ir_p[g]  <= ir_a[g];
      ack_p[g] <= ack_a[g];
    end
  end

  task automatic check_park(int d, string nm);
    drv_a[d]  = 1'b1;
    dout_a[d] = PARK;
    #1;
    ntests++;
    if (ir_a[d] !== 1'b0 || ack_a[d] !== 1'b0 || bus_mon[d] !== PARK) begin
      nfail++;
      $display("FAIL %s dut%0d got ir=%b ack=%b bus=%h, need 0 0 %h",
               nm, d, ir_a[d], ack_a[d], bus_mon[d], PARK);
    end
    drv_a[d] = 1'b0;
  endtask

  task automatic do_req(int d, bit w, bit r, logic [15:0] a,
                        logic [15:0] wd, int hold);
    exp_t e;
    bit   got;
    @(negedge clk);
    addr_a[d] = a;
    rd_a[d]   = r;
    wr_a[d]   = w;
    drv_a[d]  = w;
    dout_a[d] = wd;
    e.d      = d;
    e.wr     = w;
    e.sample = cyc + 1;
    if (w) begin
      e.data = wd;
      model[d][a[7:0]] = wd;
      known[d].push_back(a);
    end else begin
      e.data = model[d][a[7:0]];
    end
    exp_q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = w ? ack_a[d] : ir_a[d];
    end
    ntests++;
    if (!got) begin
      nfail++;
      $display("FAIL timeout dut%0d got no response, need one", d);
    end
    repeat (hold) @(negedge clk);
    rd_a[d]  = 1'b0;
    wr_a[d]  = 1'b0;
    drv_a[d] = 1'b0;
    @(negedge clk);
    check_park(d, "release");
  endtask

  task automatic abort_req(int d, bit w, logic [15:0] a,
                           logic [15:0] wd, bit use_rst);
    bit seen;
    @(negedge clk);
    addr_a[d] = a;
    rd_a[d]   = ~w;
    wr_a[d]   = w;
    drv_a[d]  = w;
    dout_a[d] = wd;
    @(posedge clk);
    #2;
    if (use_rst) begin
      reset_n = 1'b0;
      #1;
      ntests++;
      if (ir_a[d] !== 1'b0 || ack_a[d] !== 1'b0) begin
        nfail++;
        $display("FAIL rst_wait dut%0d got ir=%b ack=%b, need 0 0",
                 d, ir_a[d], ack_a[d]);
      end
    end
    rd_a[d]  = 1'b0;
    wr_a[d]  = 1'b0;
    drv_a[d] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (lat_of(d) + 3) begin
      @(negedge clk);
      if (ir_a[d] || ack_a[d]) seen = 1'b1;
    end
    ntests++;
    if (seen) begin
      nfail++;
      $display("FAIL abort dut%0d got a response, need none", d);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rd_a[g]   = 1'b0;
      wr_a[g]   = 1'b0;
      addr_a[g] = '0;
      drv_a[g]  = 1'b0;
      dout_a[g] = '0;
      ir_p[g]   = 1'b0;
      ack_p[g]  = 1'b0;
      hold_v[g] = '0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) check_park(g, "reset");
    reset_n = 1'b1;

    do_req(0, 1, 0, 16'h0012, 16'hBEEF, 0);
    do_req(0, 0, 1, 16'h0012, 16'h0, 5);
    do_req(0, 1, 0, 16'h0105, 16'h1234, 1);
    do_req(0, 0, 1, 16'h0005, 16'h0, 0);

    do_req(0, 1, 0, 16'h0020, 16'h0000, 0);
    abort_req(0, 1, 16'h0020, 16'hDEAD, 0);
    do_req(0, 0, 1, 16'h0020, 16'h0, 0);

    do_req(0, 1, 1, 16'h0040, 16'hC0DE, 2);
    do_req(0, 0, 1, 16'h0040, 16'h0, 0);

    abort_req(0, 0, 16'h0012, 16'h0, 1);
    do_req(0, 1, 0, 16'h0030, 16'h1111, 0);
    abort_req(0, 1, 16'h0030, 16'h2222, 1);
    do_req(0, 0, 1, 16'h0030, 16'h0, 0);

    begin
      exp_t e;
      @(negedge clk);
      addr_a[0] = 16'h0012;
      rd_a[0]   = 1'b1;
      e.d = 0; e.wr = 1'b0; e.sample = cyc + 1;
      e.data = model[0][8'h12];
      exp_q.push_back(e);
      repeat (lat_of(0) + 1) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      rd_a[0] = 1'b0;
      check_park(0, "rst_resp");
      @(negedge clk);
      reset_n = 1'b1;
    end

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      if (known[0].size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        do_req(0, 1, 0, a, 16'($urandom), $urandom_range(0, 3));
      end else begin
        a = known[0][$urandom_range(0, known[0].size() - 1)];
        a[15:8] = 8'($urandom);
        do_req(0, 0, 1, a, 16'h0, $urandom_range(0, 3));
      end
    end

    for (int d = 1; d < 3; d++) begin
      do_req(d, 1, 0, 16'h0077, 16'h5A5A + 16'(d), 0);
      do_req(d, 0, 1, 16'h0377, 16'h0, 1);
    end

    repeat (3) @(negedge clk);
    ntests++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL pending got %0d left, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
